// File: rtl/tod_clock_pkg.sv
// tod_pkg: shared widths, limits, time record and the day-window helper
// used by the tod_clock block and its interface.
package tod_pkg;

  localparam int unsigned HOURS_W = 5;
  localparam int unsigned MIN_W   = 6;
  localparam int unsigned SEC_W   = 6;

  localparam logic [HOURS_W-1:0] MAX_H = 5'd23;
  localparam logic [MIN_W-1:0]   MAX_M = 6'd59;
  localparam logic [SEC_W-1:0]   MAX_S = 6'd59;

  typedef struct packed {
    logic [HOURS_W-1:0] hours;
    logic [MIN_W-1:0]   minutes;
    logic [SEC_W-1:0]   seconds;
  } tod_t;

  // Day mode covers start <= h < stop.
  function automatic logic in_day_window(input logic [HOURS_W-1:0] h,
                                         input int unsigned start,
                                         input int unsigned stop);
    return (32'(h) >= start) && (32'(h) < stop);
  endfunction

endpackage

// File: rtl/tod_clock_if.sv
// tod_clock_if: run/load request bundle and the time/flag outputs.
// master drives requests, slave (the clock block) drives the time.
interface tod_clock_if;
  import tod_pkg::*;

  logic               run;
  logic               load;
  logic [HOURS_W-1:0] load_hours;
  logic [MIN_W-1:0]   load_minutes;
  logic [HOURS_W-1:0] hours;
  logic [MIN_W-1:0]   minutes;
  logic [SEC_W-1:0]   seconds;
  logic               min_tick;
  logic               day_mode;
  logic               load_err;

  modport master (
    output run, load, load_hours, load_minutes,
    input  hours, minutes, seconds, min_tick, day_mode, load_err
  );

  modport slave (
    input  run, load, load_hours, load_minutes,
    output hours, minutes, seconds, min_tick, day_mode, load_err
  );
endinterface

// File: rtl/tod_clock_prescaler.sv
// tod_prescaler: divides the system clock down to one sec_adv per
// TICKS_PER_SEC cycles of run=1; restart returns the count to 0.
module tod_prescaler #(
  parameter int unsigned TICKS_PER_SEC = 100
) (
  input  logic clock,
  input  logic clear,
  input  logic run,
  input  logic restart,
  output logic sec_adv
);
  localparam int unsigned   CW   = $clog2(TICKS_PER_SEC);
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

  logic [CW-1:0] count;

  // Wrapping cycle counter, frozen while run is low.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      count <= '0;
    end else if (restart) begin
      count <= '0;
    end else if (run) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

  assign sec_adv = run && (count == LAST);
endmodule

// File: rtl/tod_clock.sv
// tod_clock: hours/minutes/seconds time-of-day source with load port,
// registered day/night flag, minute tick and load error pulse.
// Build option: TOD_FAST_SIM_EN bypasses the prescaler and seconds stage so
// that every run cycle advances one minute.
module tod_clock
  import tod_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 100,
  parameter int unsigned RESET_H       = 0,
  parameter int unsigned RESET_M       = 0,
  parameter int unsigned DAY_START_H   = 5,
  parameter int unsigned DAY_END_H     = 22
) (
  input logic        clock,
  input logic        clear,
  tod_clock_if.slave bus
);
  localparam tod_t RESET_TOD = '{hours:   HOURS_W'(RESET_H),
                                 minutes: MIN_W'(RESET_M),
                                 seconds: '0};
  localparam logic RESET_DAY = in_day_window(HOURS_W'(RESET_H), DAY_START_H, DAY_END_H);

  tod_t cur;
  tod_t nxt;
  logic tick_nxt;
  logic load_ok;
  logic load_bad;
  logic min_adv;
  logic min_tick_r;
  logic load_err_r;
  logic day_r;

  assign load_ok  = bus.load && (bus.load_hours <= MAX_H) && (bus.load_minutes <= MAX_M);
  assign load_bad = bus.load && !load_ok;

`ifdef TOD_FAST_SIM_EN
  assign min_adv = bus.run;
`else
  logic sec_adv;

  tod_prescaler #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_prescaler (
    .clock   (clock),
    .clear   (clear),
    .run     (bus.run),
    .restart (load_ok),
    .sec_adv (sec_adv)
  );

  assign min_adv = sec_adv && (cur.seconds == MAX_S);
`endif

  // Next time: an accepted load overrides any advance in the same cycle.
  always_comb begin
    nxt      = cur;
    tick_nxt = 1'b0;
    if (load_ok) begin
      nxt.hours   = bus.load_hours;
      nxt.minutes = bus.load_minutes;
      nxt.seconds = '0;
      tick_nxt    = 1'b1;
    end else begin
`ifndef TOD_FAST_SIM_EN
      if (sec_adv) begin
        nxt.seconds = (cur.seconds == MAX_S) ? '0 : cur.seconds + 1'b1;
      end
`endif
      if (min_adv) begin
        tick_nxt = 1'b1;
        if (cur.minutes == MAX_M) begin
          nxt.minutes = '0;
          nxt.hours   = (cur.hours == MAX_H) ? '0 : cur.hours + 1'b1;
        end else begin
          nxt.minutes = cur.minutes + 1'b1;
        end
      end
    end
  end

  // Time and flag registers; day_mode tracks next-state hours so it moves with hours.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      cur        <= RESET_TOD;
      min_tick_r <= 1'b0;
      load_err_r <= 1'b0;
      day_r      <= RESET_DAY;
    end else begin
      cur        <= nxt;
      min_tick_r <= tick_nxt;
      load_err_r <= load_bad;
      day_r      <= in_day_window(nxt.hours, DAY_START_H, DAY_END_H);
    end
  end

  assign bus.hours    = cur.hours;
  assign bus.minutes  = cur.minutes;
  assign bus.seconds  = cur.seconds;
  assign bus.min_tick = min_tick_r;
  assign bus.load_err = load_err_r;
  assign bus.day_mode = day_r;
endmodule

// File: tb/tb_tod_clock.sv
// tb_tod_clock: directed stimulus with a queue-based scoreboard for
// tod_clock (TICKS_PER_SEC=4, reset 04:59, day window 5..22).
module tb_tod_clock;
  import tod_pkg::*;

  typedef struct {
    int           at;
    logic [4:0]   h;
    logic [5:0]   m;
    logic [5:0]   s;
    logic         day;
    string        tag;
  } exp_t;

  exp_t exp_q[$];
  int   tick_q[$];
  int   err_q[$];

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  logic clk    = 1'b0;
  logic clear;

  tod_clock_if bus ();

  tod_clock #(
    .TICKS_PER_SEC (4),
    .RESET_H       (4),
    .RESET_M       (59),
    .DAY_START_H   (5),
    .DAY_END_H     (22)
  ) dut (
    .clock (clk),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_state(input int at, input int h, input int m, input int s,
                              input logic day, input string tag);
    exp_t e;
    e.at  = at;
    e.h   = 5'(h);
    e.m   = 6'(m);
    e.s   = 6'(s);
    e.day = day;
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic step_to(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_load(input int h, input int m);
    bus.load         = 1'b1;
    bus.load_hours   = 5'(h);
    bus.load_minutes = 6'(m);
  endtask

  // Monitor: compares scheduled snapshots and every pulse the DUT emits.
  always @(negedge clk) begin
    exp_t e;
    int   t;
    while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
      e = exp_q.pop_front();
      checks++;
      if (e.at != cyc ||
          {bus.hours, bus.minutes, bus.seconds, bus.day_mode} !== {e.h, e.m, e.s, e.day}) begin
        errors++;
        $display("FAIL %s cyc %0d: got %0d:%0d:%0d day=%b, want %0d:%0d:%0d day=%b (due cyc %0d)",
                 e.tag, cyc, bus.hours, bus.minutes, bus.seconds, bus.day_mode,
                 e.h, e.m, e.s, e.day, e.at);
      end
    end
    while (tick_q.size() > 0 && tick_q[0] < cyc) begin
      t = tick_q.pop_front();
      checks++;
      errors++;
      $display("FAIL min_tick_missing: got none, want pulse at cyc %0d", t);
    end
    if (bus.min_tick !== 1'b0) begin
      checks++;
      if (tick_q.size() == 0) begin
        errors++;
        $display("FAIL min_tick_unexpected: got %b at cyc %0d, want 0", bus.min_tick, cyc);
      end else begin
        t = tick_q.pop_front();
        if (t != cyc || bus.min_tick !== 1'b1) begin
          errors++;
          $display("FAIL min_tick_timing: got %b at cyc %0d, want 1 at cyc %0d", bus.min_tick, cyc, t);
        end
      end
    end
    while (err_q.size() > 0 && err_q[0] < cyc) begin
      t = err_q.pop_front();
      checks++;
      errors++;
      $display("FAIL load_err_missing: got none, want pulse at cyc %0d", t);
    end
    if (bus.load_err !== 1'b0) begin
      checks++;
      if (err_q.size() == 0) begin
        errors++;
        $display("FAIL load_err_unexpected: got %b at cyc %0d, want 0", bus.load_err, cyc);
      end else begin
        t = err_q.pop_front();
        if (t != cyc || bus.load_err !== 1'b1) begin
          errors++;
          $display("FAIL load_err_timing: got %b at cyc %0d, want 1 at cyc %0d", bus.load_err, cyc, t);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, want finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c2, c3, c4;
    clear            = 1'b0;
    bus.run          = 1'b0;
    bus.load         = 1'b0;
    bus.load_hours   = '0;
    bus.load_minutes = '0;

    step_to(1);
    expect_state(1, 4, 59, 0, 1'b0, "reset");
    step_to(2);
    clear = 1'b1;
    expect_state(3, 4, 59, 0, 1'b0, "idle_after_clear");
    step_to(4);

`ifdef TOD_FAST_SIM_EN
    c0 = cyc;
    bus.run = 1'b1;
    for (int k = 1; k <= 60; k++) tick_q.push_back(c0 + k);
    expect_state(c0 + 1,  5, 0,  0, 1'b1, "fast_first_min");
    expect_state(c0 + 60, 5, 59, 0, 1'b1, "fast_60_cycles");
    step_to(c0 + 60);
    bus.run = 1'b0;
    drive_load(21, 30);
    tick_q.push_back(c0 + 61);
    expect_state(c0 + 61, 21, 30, 0, 1'b1, "fast_load");
    step_to(c0 + 61);
    bus.load = 1'b0;
    expect_state(c0 + 70, 21, 30, 0, 1'b1, "fast_frozen");
    step_to(c0 + 72);
`else
    // Real-time path: 4 cycles per second.
    c0 = cyc;
    bus.run = 1'b1;
    expect_state(c0 + 4,   4, 59, 1,  1'b0, "first_sec");
    expect_state(c0 + 232, 4, 59, 58, 1'b0, "at_04_59_58");
    expect_state(c0 + 239, 4, 59, 59, 1'b0, "at_04_59_59");
    expect_state(c0 + 240, 5, 0,  0,  1'b1, "hour_roll_day_on");
    tick_q.push_back(c0 + 240);
    step_to(c0 + 240);

    bus.run = 1'b0;
    expect_state(c0 + 245, 5, 0, 0, 1'b1, "frozen_5");
    expect_state(c0 + 290, 5, 0, 0, 1'b1, "frozen_50");
    step_to(c0 + 290);

    c2 = cyc;
    bus.run = 1'b1;
    expect_state(c2 + 3, 5, 0, 0, 1'b1, "resume_hold");
    expect_state(c2 + 4, 5, 0, 1, 1'b1, "resume_sec");
    step_to(c2 + 4);

    drive_load(24, 10);
    err_q.push_back(c2 + 5);
    expect_state(c2 + 5, 5, 0, 1, 1'b1, "reject_unchanged");
    step_to(c2 + 5);
    bus.load = 1'b0;
    expect_state(c2 + 8, 5, 0, 2, 1'b1, "reject_advances");

    step_to(c2 + 11);
    drive_load(5, 60);
    err_q.push_back(c2 + 12);
    expect_state(c2 + 12, 5, 0, 3, 1'b1, "reject_with_adv");
    step_to(c2 + 12);
    bus.load = 1'b0;

    step_to(c2 + 15);
    drive_load(21, 30);
    tick_q.push_back(c2 + 16);
    expect_state(c2 + 16, 21, 30, 0, 1'b1, "load_wins_over_adv");
    step_to(c2 + 16);
    bus.load = 1'b0;
    expect_state(c2 + 19, 21, 30, 0, 1'b1, "load_prescaler_zero");
    expect_state(c2 + 20, 21, 30, 1, 1'b1, "load_first_sec");
    step_to(c2 + 20);

    c3 = cyc;
    drive_load(23, 59);
    tick_q.push_back(c3 + 1);
    expect_state(c3 + 1, 23, 59, 0, 1'b0, "load_23_59");
    step_to(c3 + 1);
    bus.load = 1'b0;
    expect_state(c3 + 240, 23, 59, 59, 1'b0, "pre_midnight");
    expect_state(c3 + 241, 0,  0,  0,  1'b0, "midnight_wrap");
    tick_q.push_back(c3 + 241);
    step_to(c3 + 243);

    c4 = cyc;
    expect_state(c4, 4, 59, 0, 1'b0, "async_clear");
    #1;
    clear = 1'b0;
    step_to(c4 + 1);
    clear = 1'b1;
    expect_state(c4 + 4, 4, 59, 0, 1'b0, "post_clear_hold");
    expect_state(c4 + 5, 4, 59, 1, 1'b0, "post_clear_sec");
    step_to(c4 + 8);
`endif

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0 || tick_q.size() != 0 || err_q.size() != 0) begin
      errors++;
      $display("FAIL queues_drained: got %0d/%0d/%0d pending, want 0/0/0",
               exp_q.size(), tick_q.size(), err_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
